rename_stage: RTL

// - Register-rename stage directly downstream of instruction decode.
// - Maps architectural rd/rs1/rs2 to physical tags through a RAT and a free list.
// - Carries decoded control fields to issue through one registered valid/ready pipeline slot.
// - Returns freed physical tags from retire to the free list.

---
 rtl/rename_pkg.sv | 42 ++++
 rtl/rename_if.sv | 41 ++++
 rtl/rename_free_list.sv | 58 +++++
 rtl/rename_stage.sv | 87 ++++++++
 4 files changed

// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
// rename_pkg : constants, tag types and control bundle for the rename stage
// Revision   : 1.0
// ============================================================================
package rename_pkg;

  localparam int ARCH_REGS  = 32;
  localparam int PHYS_REGS  = 64;
  localparam int PTAG_W     = $clog2(PHYS_REGS);
  localparam int FREE_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int AREG_W     = $clog2(ARCH_REGS);
  localparam int FPTR_W     = $clog2(FREE_DEPTH);
  localparam int CNT_W      = FPTR_W + 1;
  localparam int CTRL_W     = 50;

  // Bit offsets of the fields packed into in_ctrl / out_ctrl
  localparam int CTRL_BMS_LSB       = 0;
  localparam int CTRL_ALUCTRL_LSB   = 1;
  localparam int CTRL_REGWRITE_LSB  = 5;
  localparam int CTRL_ALUSRC_LSB    = 6;
  localparam int CTRL_LOADSTORE_LSB = 7;
  localparam int CTRL_IMM_LSB       = 8;
  localparam int CTRL_FUNC3_LSB     = 40;
  localparam int CTRL_OPCODE_LSB    = 43;

  typedef logic [PTAG_W-1:0] ptag_t;
  typedef logic [AREG_W-1:0] areg_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [31:0] imm;
    logic        loadstore;
    logic        alusrc;
    logic        regwrite;
    logic [3:0]  alucontrol;
    logic        bms;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/rename_if.sv
`default_nettype none
// ============================================================================
// rename_if : decode-side, issue-side and retire-side signals of rename_stage
// Revision  : 1.0
// ============================================================================
interface rename_if;
  import rename_pkg::*;

  logic  in_valid;
  logic  in_ready;
  areg_t in_rd;
  areg_t in_rs1;
  areg_t in_rs2;
  logic  in_regwrite;
  ctrl_t in_ctrl;

  logic  out_valid;
  logic  out_ready;
  ptag_t out_prs1;
  ptag_t out_prs2;
  ptag_t out_prd;
  ptag_t out_old_prd;
  ctrl_t out_ctrl;

  logic  retire_valid;
  ptag_t retire_tag;

  modport master (
    output in_valid, in_rd, in_rs1, in_rs2, in_regwrite, in_ctrl,
    output out_ready, retire_valid, retire_tag,
    input  in_ready, out_valid, out_prs1, out_prs2, out_prd, out_old_prd, out_ctrl
  );

  modport slave (
    input  in_valid, in_rd, in_rs1, in_rs2, in_regwrite, in_ctrl,
    input  out_ready, retire_valid, retire_tag,
    output in_ready, out_valid, out_prs1, out_prs2, out_prd, out_old_prd, out_ctrl
  );

endinterface
`default_nettype wire

// File: rtl/rename_free_list.sv
`default_nettype none
// ============================================================================
// rename_free_list : circular FIFO of free physical tags, preloaded at reset
// Revision         : 1.0
// ============================================================================
module rename_free_list
  import rename_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             pop,
  input  wire logic             push,
  input  wire ptag_t            push_tag,
  output      ptag_t            head_tag,
  output      logic [CNT_W-1:0] count
);

  ptag_t             r_mem [FREE_DEPTH];
  logic [FPTR_W-1:0] r_head;
  logic [FPTR_W-1:0] r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              w_push_ok;

  // A push into a full list is dropped rather than corrupting the head slot
  assign w_push_ok = push && (r_count != CNT_W'(FREE_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FREE_DEPTH; i++) begin
        r_mem[i] <= PTAG_W'(ARCH_REGS + i);
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(FREE_DEPTH);
    end else begin
      if (w_push_ok) begin
        r_mem[r_tail] <= push_tag;
        r_tail        <= r_tail + FPTR_W'(1);
      end
      if (pop) begin
        r_head <= r_head + FPTR_W'(1);
      end
      case ({pop, w_push_ok})
        2'b10:   r_count <= r_count - CNT_W'(1);
        2'b01:   r_count <= r_count + CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_tag = r_mem[r_head];
  assign count    = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (r_count == CNT_W'(FREE_DEPTH))));

endmodule
`default_nettype wire

// File: rtl/rename_stage.sv
`default_nettype none
// ============================================================================
// rename_stage : RAT lookup, free-list allocation and one registered issue slot
// Revision     : 1.0
// ============================================================================
module rename_stage
  import rename_pkg::*;
(
  input wire logic clk,
  input wire logic rst_n,
  rename_if.slave  bus
);

  ptag_t            r_rat [ARCH_REGS];
  logic             r_out_valid;
  ptag_t            r_prs1;
  ptag_t            r_prs2;
  ptag_t            r_prd;
  ptag_t            r_old_prd;
  ctrl_t            r_ctrl;

  logic             w_alloc;
  logic             w_ready;
  logic             w_accept;
  logic             w_pop;
  logic             w_push;
  ptag_t            w_head_tag;
  logic [CNT_W-1:0] w_free_count;

  assign w_alloc  = bus.in_regwrite && (bus.in_rd != '0);
  // Registered count only: a retire in this same cycle cannot release a stall
  assign w_ready  = (!r_out_valid || bus.out_ready) && (!w_alloc || (w_free_count != '0));
  assign w_accept = bus.in_valid && w_ready;
  assign w_pop    = w_accept && w_alloc;
  assign w_push   = bus.retire_valid && (bus.retire_tag != '0);

  rename_free_list u_free_list (
    .clk      (clk),
    .rst_n    (rst_n),
    .pop      (w_pop),
    .push     (w_push),
    .push_tag (bus.retire_tag),
    .head_tag (w_head_tag),
    .count    (w_free_count)
  );

  // x0 is never allocated, so RAT[0] keeps p0 forever
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_rat[i] <= PTAG_W'(i);
      end
    end else if (w_pop) begin
      r_rat[bus.in_rd] <= w_head_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_prs1      <= '0;
      r_prs2      <= '0;
      r_prd       <= '0;
      r_old_prd   <= '0;
      r_ctrl      <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_prs1      <= r_rat[bus.in_rs1];
      r_prs2      <= r_rat[bus.in_rs2];
      r_prd       <= w_alloc ? w_head_tag : '0;
      r_old_prd   <= w_alloc ? r_rat[bus.in_rd] : '0;
      r_ctrl      <= bus.in_ctrl;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_prs1    = r_prs1;
  assign bus.out_prs2    = r_prs2;
  assign bus.out_prd     = r_prd;
  assign bus.out_old_prd = r_old_prd;
  assign bus.out_ctrl    = r_ctrl;

endmodule
`default_nettype wire
